mul_issue_ctrl: RTL and testbench

- Upstream issue stage for the 32x32 signed sequential multiplier.
- Buffers tagged operand pairs from a valid/ready producer in a small FIFO.
- Issues one operation at a time to the multiplier with a single-cycle enable, tracks it to completion, and emits a one-cycle done strobe with the matching tag.
- The consumer reads the 64-bit product directly from the multiplier output while the strobe is high.

---
 rtl/mul_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the 32x32 signed sequential multiplier: operand FIFO plus IDLE/ISSUE/WAIT/DONE sequencer.
// Optional zero-operand bypass is enabled by defining MUL_ZERO_SKIP_EN.
module mul_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                     CLK_i,
    input  logic                     RSTN_i,
    input  logic                     S_VALID_i,
    output logic                     S_READY_o,
    input  logic [31:0]              S_DIN1_i,
    input  logic [31:0]              S_DIN2_i,
    input  logic [TAG_W-1:0]         S_TAG_i,
    input  logic                     FLUSH_i,
    output logic                     MUL_EN_o,
    output logic [31:0]              MUL_DIN1_o,
    output logic [31:0]              MUL_DIN2_o,
    input  logic                     MUL_BUSY_i,
    input  logic                     MUL_VALID_i,
    output logic                     DONE_o,
    output logic [TAG_W-1:0]         DONE_TAG_o,
    output logic                     DONE_ZERO_o,
    output logic                     ERR_o,
    output logic [$clog2(DEPTH):0]   LEVEL_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       mem1_q [DEPTH];
    logic [31:0]       mem1_d [DEPTH];
    logic [31:0]       mem2_q [DEPTH];
    logic [31:0]       mem2_d [DEPTH];
    logic [TAG_W-1:0]  memt_q [DEPTH];
    logic [TAG_W-1:0]  memt_d [DEPTH];
    logic [31:0]       din1_q, din1_d, din2_q, din2_d;
    logic [TAG_W-1:0]  tag_q, tag_d, done_tag_q, done_tag_d;
    logic              done_zero_q, done_zero_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              s_ready, push, pop, zero_hit;
    logic [31:0]       head1, head2;
    logic [TAG_W-1:0]  head_tag;

    // Ready comes from registered occupancy only, so no input can reach it combinationally.
    assign s_ready  = (count_q != CW'(DEPTH));
    assign push     = S_VALID_i & s_ready & ~FLUSH_i;
    assign pop      = (state_q == IDLE) & (count_q != '0) & ~MUL_BUSY_i & ~FLUSH_i;
    assign head1    = mem1_q[rd_ptr_q];
    assign head2    = mem2_q[rd_ptr_q];
    assign head_tag = memt_q[rd_ptr_q];

`ifdef MUL_ZERO_SKIP_EN
    assign zero_hit = (head1 == 32'd0) | (head2 == 32'd0);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem1_q      <= '{default: '0};
            mem2_q      <= '{default: '0};
            memt_q      <= '{default: '0};
            din1_q      <= '0;
            din2_q      <= '0;
            tag_q       <= '0;
            done_tag_q  <= '0;
            done_zero_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem1_q      <= mem1_d;
            mem2_q      <= mem2_d;
            memt_q      <= memt_d;
            din1_q      <= din1_d;
            din2_q      <= din2_d;
            tag_q       <= tag_d;
            done_tag_q  <= done_tag_d;
            done_zero_q <= done_zero_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem1_d      = mem1_q;
        mem2_d      = mem2_q;
        memt_d      = memt_q;
        din1_d      = din1_q;
        din2_d      = din2_q;
        tag_d       = tag_q;
        done_tag_d  = done_tag_q;
        done_zero_d = 1'b0;
        err_d       = err_q;
        tmo_d       = tmo_q;

        if (push) begin
            mem1_d[wr_ptr_q] = S_DIN1_i;
            mem2_d[wr_ptr_q] = S_DIN2_i;
            memt_d[wr_ptr_q] = S_TAG_i;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (FLUSH_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    tag_d = head_tag;
                    if (zero_hit) begin
                        done_tag_d  = head_tag;
                        done_zero_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        din1_d  = head1;
                        din2_d  = head2;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // A timeout is treated as a completion so the queue keeps draining.
                if (MUL_VALID_i & ~MUL_BUSY_i) begin
                    done_tag_d = tag_q;
                    state_d    = DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    done_tag_d = tag_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MUL_EN_o    = (state_q == ISSUE);
        DONE_o      = (state_q == DONE);
        S_READY_o   = s_ready;
        MUL_DIN1_o  = din1_q;
        MUL_DIN2_o  = din2_q;
        DONE_TAG_o  = done_tag_q;
        DONE_ZERO_o = done_zero_q;
        ERR_o       = err_q;
        LEVEL_o     = count_q;
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural 32-cycle sequential multiplier attached.
module tb_mul_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [31:0]       s_din1 = '0;
    logic [31:0]       s_din2 = '0;
    logic [TAG_W-1:0]  s_tag = '0;
    logic              flush = 1'b0;
    logic              mul_en;
    logic [31:0]       mul_din1, mul_din2;
    logic              mul_busy, mul_valid;
    logic              done, done_zero, err;
    logic [TAG_W-1:0]  done_tag;
    logic [2:0]        level;

    mul_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(63)) dut (
        .CLK_i(clk), .RSTN_i(rst_n),
        .S_VALID_i(s_valid), .S_READY_o(s_ready),
        .S_DIN1_i(s_din1), .S_DIN2_i(s_din2), .S_TAG_i(s_tag),
        .FLUSH_i(flush),
        .MUL_EN_o(mul_en), .MUL_DIN1_o(mul_din1), .MUL_DIN2_o(mul_din2),
        .MUL_BUSY_i(mul_busy), .MUL_VALID_i(mul_valid),
        .DONE_o(done), .DONE_TAG_o(done_tag), .DONE_ZERO_o(done_zero),
        .ERR_o(err), .LEVEL_o(level)
    );

    // Multiplier model: busy for 32 cycles after EN, then VALID with the product.
    logic               m_busy, m_valid, hang_q;
    logic               hang_arm = 1'b0;
    logic [5:0]         m_cnt;
    logic signed [31:0] m_a, m_b;
    logic signed [63:0] m_dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= '0;
            m_a <= '0; m_b <= '0; m_dout <= '0; hang_q <= 1'b0;
        end else begin
            if (mul_en) begin
                m_busy <= 1'b1; m_valid <= 1'b0; m_cnt <= 6'd32;
                m_a <= mul_din1; m_b <= mul_din2;
            end else if (m_busy) begin
                if (m_cnt == 6'd1) begin
                    m_busy <= 1'b0; m_valid <= 1'b1; m_dout <= m_a * m_b;
                end
                m_cnt <= m_cnt - 6'd1;
            end
            hang_q <= hang_arm & (hang_q | mul_en);
        end
    end
    assign mul_busy  = m_busy | hang_q;
    assign mul_valid = m_valid & ~hang_q;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      prod;
        bit               chk_dout;
        bit               zero;
        int               lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int en_cyc = 0;
    int en_count = 0;
    int push_cyc = 0;
    int max_level = 0;
    bit saw_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every DONE strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_en) begin
                en_count++;
                en_cyc = cyc;
            end
            if (int'(level) > max_level) max_level = int'(level);
            if (done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 64'(done_tag), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("done_tag", 64'(done_tag), 64'(e.tag));
                    check_output("done_zero", 64'(done_zero), 64'(e.zero));
                    if (e.chk_dout) check_output("product", m_dout, e.prod);
                    if (e.lat != 0) check_output("done_latency", 64'(cyc - en_cyc), 64'(e.lat));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                                  input bit to_sb, input logic [63:0] prod, input bit chk_dout,
                                  input bit zero, input int lat);
        int guard;
        exp_t e;
        @(negedge clk);
        s_valid = 1'b1; s_din1 = a; s_din2 = b; s_tag = t;
        guard = 0;
        while (!s_ready && guard < 500) begin
            saw_full = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check_output("push_accept", 64'(s_ready), 64'd1);
        @(posedge clk);
        if (to_sb) begin
            e.tag = t; e.prod = prod; e.chk_dout = chk_dout; e.zero = zero; e.lat = lat;
            sb.push_back(e);
        end
        #1;
        push_cyc = cyc;
    endtask

    task automatic end_push();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_en(input int prev);
        int guard;
        guard = 0;
        while (en_count == prev && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check_output("en_seen", 64'(en_count != prev), 64'd1);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 3000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check_output("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int prev;

        // Reset values while reset is held
        #12;
        check_output("rst_ready", 64'(s_ready), 64'd1);
        check_output("rst_mul_en", 64'(mul_en), 64'd0);
        check_output("rst_din1", 64'(mul_din1), 64'd0);
        check_output("rst_din2", 64'(mul_din2), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_done_tag", 64'(done_tag), 64'd0);
        check_output("rst_done_zero", 64'(done_zero), 64'd0);
        check_output("rst_err", 64'(err), 64'd0);
        check_output("rst_level", 64'(level), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);

        $display("[TB] single op 7 * -3, tag 5");
        prev = en_count;
        apply_stimulus(32'd7, 32'hFFFF_FFFD, 4'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b0, 34);
        end_push();
        wait_en(prev);
        check_output("first_en_latency", 64'(en_cyc - push_cyc + 1), 64'd2);
        wait_drain();
        check_output("single_en_count", 64'(en_count - prev), 64'd1);
        idle_cycles(5);
        check_output("done_tag_held", 64'(done_tag), 64'd5);

        $display("[TB] burst of 6");
        max_level = 0; saw_full = 1'b0;
        apply_stimulus(32'd1,         32'd1,         4'd0, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 34);
        apply_stimulus(32'd2,         32'hFFFF_FFFE, 4'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 34);
        apply_stimulus(32'h0001_0000, 32'h0001_0000, 4'd2, 1'b1, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 34);
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 34);
        apply_stimulus(32'h7FFF_FFFF, 32'd2,         4'd4, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0, 34);
        apply_stimulus(32'h8000_0000, 32'd2,         4'd5, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 34);
        end_push();
        check_output("burst_ready_low", 64'(saw_full), 64'd1);
        wait_drain();
        check_output("burst_max_level", 64'(max_level), 64'd4);

        $display("[TB] flush during WAIT");
        prev = en_count;
        apply_stimulus(32'd3, 32'd4, 4'd8, 1'b1, 64'd12, 1'b1, 1'b0, 34);
        end_push();
        wait_en(prev);
        apply_stimulus(32'd5, 32'd6, 4'd9,  1'b0, 64'd0, 1'b0, 1'b0, 0);
        apply_stimulus(32'd5, 32'd7, 4'd10, 1'b0, 64'd0, 1'b0, 1'b0, 0);
        apply_stimulus(32'd5, 32'd8, 4'd11, 1'b0, 64'd0, 1'b0, 1'b0, 0);
        end_push();
        check_output("pre_flush_level", 64'(level), 64'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("post_flush_level", 64'(level), 64'd0);
        wait_drain();
        idle_cycles(40);
        check_output("flush_en_count", 64'(en_count - prev), 64'd1);

        $display("[TB] timeout with a hung multiplier");
        check_output("err_before_timeout", 64'(err), 64'd0);
        hang_arm = 1'b1;
        apply_stimulus(32'd1, 32'd2, 4'd6, 1'b1, 64'd0, 1'b0, 1'b0, 64);
        end_push();
        wait_drain();
        check_output("err_raised", 64'(err), 64'd1);
        hang_arm = 1'b0;
        idle_cycles(10);
        check_output("err_sticky", 64'(err), 64'd1);

        $display("[TB] reset during WAIT");
        prev = en_count;
        apply_stimulus(32'd5, 32'd5, 4'd3, 1'b0, 64'd0, 1'b0, 1'b0, 0);
        end_push();
        wait_en(prev);
        idle_cycles(10);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_mul_en", 64'(mul_en), 64'd0);
        check_output("arst_din1", 64'(mul_din1), 64'd0);
        check_output("arst_done_tag", 64'(done_tag), 64'd0);
        check_output("arst_err", 64'(err), 64'd0);
        check_output("arst_level", 64'(level), 64'd0);
        check_output("arst_ready", 64'(s_ready), 64'd1);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(60);

        $display("[TB] op after reset");
        prev = en_count;
        apply_stimulus(32'hFFFF_FFFB, 32'd6, 4'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FFE2, 1'b1, 1'b0, 34);
        end_push();
        wait_en(prev);
        check_output("post_reset_en_latency", 64'(en_cyc - push_cyc + 1), 64'd2);
        wait_drain();

`ifdef MUL_ZERO_SKIP_EN
        $display("[TB] zero skip");
        prev = en_count;
        apply_stimulus(32'd0, 32'h1234, 4'd2, 1'b1, 64'd0, 1'b0, 1'b1, 0);
        end_push();
        wait_drain();
        check_output("zero_skip_no_en", 64'(en_count - prev), 64'd0);
`endif

        idle_cycles(5);
        check_output("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
